// File: rtl/mem8x8_ctrl.sv
// rtl/mem8x8_ctrl.sv - 8x8 memory with valid/ready access controller and one-hot word-line select
// Optional per-word even parity is enabled by defining MEM8X8_PARITY_EN.
module mem8x8_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [(1<<ADDR_W)-1:0]     wl_sel
`ifdef MEM8X8_PARITY_EN
  ,
  input  logic                       inj_perr,
  output logic                       rsp_perr
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   w_word;
  logic                w_accept;
  logic                w_commit;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign w_commit  = (r_state == S_ACCESS);
  // Post-access word value: a write echoes its own data.
  assign w_word    = r_we ? r_wdata : r_mem[r_addr];
  assign rsp_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wl_sel    = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        wl_sel = DEPTH'(1) << r_addr;
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_commit) begin
        r_rdata <= w_word;
        if (r_we) r_mem[r_addr] <= r_wdata;
      end
    end
  end

`ifdef MEM8X8_PARITY_EN
  logic       r_inj;
  logic       r_perr;
  logic       r_par [DEPTH];
  logic       w_par_word;

  assign w_par_word = r_we ? ((^r_wdata) ^ r_inj) : r_par[r_addr];
  assign rsp_perr   = rsp_valid & r_perr;

  // All-zero words with zero parity bits are consistent after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj  <= 1'b0;
      r_perr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else begin
      if (w_accept) r_inj <= inj_perr;
      if (w_commit) begin
        r_perr <= w_par_word ^ (^w_word);
        if (r_we) r_par[r_addr] <= w_par_word;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// tb/tb_mem8x8_ctrl.sv - scoreboard bench for mem8x8_ctrl
// Parity checks are included when MEM8X8_PARITY_EN is defined.
module tb_mem8x8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic [7:0] wl_sel;
`ifdef MEM8X8_PARITY_EN
  logic       inj_perr = 1'b0;
  logic       rsp_perr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] q_rsp [$];
  logic [7:0] q_sel [$];

  mem8x8_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .wl_sel    (wl_sel)
`ifdef MEM8X8_PARITY_EN
    ,
    .inj_perr  (inj_perr),
    .rsp_perr  (rsp_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a select or a response.
  always @(negedge clk) begin
    logic [8:0] e;
    if (wl_sel !== 8'h00) begin
      if (q_sel.size() == 0) check("unexpected wl_sel", {24'h0, wl_sel}, 32'h0);
      else check("wl_sel", {24'h0, wl_sel}, {24'h0, q_sel.pop_front()});
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q_rsp.size() == 0) begin
        check("unexpected rsp", 32'h1, 32'h0);
      end else begin
        e = q_rsp.pop_front();
        check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e[7:0]});
`ifdef MEM8X8_PARITY_EN
        check("rsp_perr", {31'h0, rsp_perr}, {31'h0, e[8]});
`endif
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that closes the response.
  task automatic do_req(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd, input logic exp_perr);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    q_sel.push_back(8'h01 << addr);
    q_rsp.push_back({exp_perr, exp_rd});
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready before accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("accept-to-rsp latency", n, 32'd2);
    n = 0;
    while (rsp_valid === 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready after rsp", {31'h0, req_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #3 rst_n = 1'b0;
    #1;
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset wl_sel", {24'h0, wl_sel}, 32'h0);
    check("reset rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 8'h00, 8'h00, 1'b0);

    do_req(1'b1, 3'd3, 8'hA5, 8'hA5, 1'b0);
    do_req(1'b0, 3'd3, 8'h00, 8'hA5, 1'b0);
    do_req(1'b0, 3'd2, 8'h00, 8'h00, 1'b0);
    do_req(1'b0, 3'd4, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 8'h10 + 8'(i), 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) do_req(1'b0, 3'(i), 8'h5A, 8'h10 + 8'(i), 1'b0);

    // Backpressure with a stray write request during RESP.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 3'd6;
    q_sel.push_back(8'h40);
    q_rsp.push_back({1'b0, 8'h16});
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd6;
        req_wdata = 8'hEE;
      end
      if (k == 3) req_valid = 1'b0;
      check("bp rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp rsp_rdata", {24'h0, rsp_rdata}, 32'h16);
      check("bp req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp idle req_ready", {31'h0, req_ready}, 32'h1);
    check("bp idle rsp_valid", {31'h0, rsp_valid}, 32'h0);
    do_req(1'b0, 3'd6, 8'h00, 8'h16, 1'b0);

    // Reset during ACCESS of a write: nothing may be committed.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 3'd5;
    req_wdata = 8'hFF;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midop req_ready", {31'h0, req_ready}, 32'h1);
    check("midop rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("midop wl_sel", {24'h0, wl_sel}, 32'h0);
    check("midop rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'd5, 8'h00, 8'h00, 1'b0);
    do_req(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

`ifdef MEM8X8_PARITY_EN
    inj_perr = 1'b1;
    do_req(1'b1, 3'd2, 8'h3C, 8'h3C, 1'b1);
    inj_perr = 1'b0;
    do_req(1'b1, 3'd3, 8'h3C, 8'h3C, 1'b0);
    do_req(1'b0, 3'd2, 8'h00, 8'h3C, 1'b1);
    do_req(1'b0, 3'd3, 8'h00, 8'h3C, 1'b0);
`endif

    repeat (3) @(posedge clk);
    check("pending wl_sel expectations", q_sel.size(), 32'd0);
    check("pending rsp expectations", q_rsp.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
